dp_ram_ctrl: RTL and testbench

Parametrised true dual-port synchronous RAM, successor to the team's fixed 8x64 dual-port RAM. Adds configurable width and depth, per-port enables, byte write enables, a selectable read-during-write mode, an optional output register stage, read-valid strobes, and deterministic address-collision handling with a collision counter. Sits between two independent single-clock masters, such as a DMA engine and a CPU-side port, that share one storage array.

---
 rtl/dp_ram_ctrl.sv | 110 +++++++++++
 tb/tb_dp_ram_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_ctrl.sv
// dp_ram_ctrl: parametrised true dual-port RAM with byte enables, selectable
// read-during-write behaviour, optional output register and collision counting.
module dp_ram_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [DATA_W/8-1:0]   be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     din_a,
  output logic [DATA_W-1:0]     dout_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     din_b,
  output logic [DATA_W-1:0]     dout_b,
  output logic                  valid_b,
  output logic                  coll,
  output logic [15:0]           coll_cnt
);
  localparam int unsigned NB          = DATA_W / 8;
  localparam int unsigned DEPTH       = 2 ** ADDR_W;
  localparam int unsigned WRITE_FIRST = 1;
  localparam int unsigned NO_CHANGE   = 2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_coll;
  logic              w_ld_a, w_ld_b;
  logic [DATA_W-1:0] w_old_a, w_old_b, w_fin_a, w_fin_b, w_rd_a, w_rd_b;

  logic              r_vld1_a, r_vld1_b, r_vld2_a, r_vld2_b;
  logic [DATA_W-1:0] r_dout1_a, r_dout1_b, r_dout2_a, r_dout2_b;
  logic              r_coll;
  logic [15:0]       r_coll_cnt;

  assign w_acc_a = en_a & rst_n;
  assign w_acc_b = en_b & rst_n;
  assign w_wr_a  = w_acc_a & we_a;
  assign w_wr_b  = w_acc_b & we_b;
  assign w_coll  = w_acc_a & w_acc_b & (addr_a == addr_b) & (we_a | we_b);
  assign w_old_a = r_mem[addr_a];
  assign w_old_b = r_mem[addr_b];

  // Merged word per port; on a shared address port a's bytes override port b's.
  always_comb begin
    w_fin_a = w_old_a;
    w_fin_b = w_old_b;
    for (int i = 0; i < int'(NB); i++) begin
      if (w_coll && we_b && be_b[i]) w_fin_a[8*i +: 8] = din_b[8*i +: 8];
      if (be_a[i])                   w_fin_a[8*i +: 8] = din_a[8*i +: 8];
      if (be_b[i])                   w_fin_b[8*i +: 8] = din_b[8*i +: 8];
      if (w_coll && we_a && be_a[i]) w_fin_b[8*i +: 8] = din_a[8*i +: 8];
    end
  end

  // Readers always see the pre-write word; only a writer may see its own merge.
  assign w_ld_a = w_acc_a & ~(we_a & (RDW_MODE == NO_CHANGE));
  assign w_ld_b = w_acc_b & ~(we_b & (RDW_MODE == NO_CHANGE));
  assign w_rd_a = (we_a && (RDW_MODE == WRITE_FIRST)) ? w_fin_a : w_old_a;
  assign w_rd_b = (we_b && (RDW_MODE == WRITE_FIRST)) ? w_fin_b : w_old_b;

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_b) r_mem[addr_b] <= w_fin_b;
    if (w_wr_a) r_mem[addr_a] <= w_fin_a;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld1_a   <= 1'b0;
      r_vld1_b   <= 1'b0;
      r_vld2_a   <= 1'b0;
      r_vld2_b   <= 1'b0;
      r_dout1_a  <= '0;
      r_dout1_b  <= '0;
      r_dout2_a  <= '0;
      r_dout2_b  <= '0;
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_vld1_a <= w_ld_a;
      r_vld1_b <= w_ld_b;
      if (w_ld_a) r_dout1_a <= w_rd_a;
      if (w_ld_b) r_dout1_b <= w_rd_b;
      // Stage 2 only advances when stage 1 was loaded.
      r_vld2_a <= r_vld1_a;
      r_vld2_b <= r_vld1_b;
      if (r_vld1_a) r_dout2_a <= r_dout1_a;
      if (r_vld1_b) r_dout2_b <= r_dout1_b;
      r_coll <= w_coll;
      if (w_coll && (r_coll_cnt != 16'hFFFF)) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  assign dout_a   = (OUT_REG != 0) ? r_dout2_a : r_dout1_a;
  assign dout_b   = (OUT_REG != 0) ? r_dout2_b : r_dout1_b;
  assign valid_a  = (OUT_REG != 0) ? r_vld2_a  : r_vld1_a;
  assign valid_b  = (OUT_REG != 0) ? r_vld2_b  : r_vld1_b;
  assign coll     = r_coll;
  assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Scoreboard bench for dp_ram_ctrl: three configurations (READ_FIRST/OUT_REG=0,
// WRITE_FIRST/OUT_REG=1, NO_CHANGE/OUT_REG=0) driven by one shared stimulus.
module tb_dp_ram_ctrl;
  localparam int NI = 3;
  localparam int MD  [NI] = '{0, 1, 2};
  localparam int ORG [NI] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [1:0]  be_a = '0, be_b = '0;
  logic [3:0]  addr_a = '0, addr_b = '0;
  logic [15:0] din_a = '0, din_b = '0;

  logic [15:0] dout_w  [6];
  logic        valid_w [6];
  logic        coll_w  [NI];
  logic [15:0] cnt_w   [NI];

  int n_vec = 0;
  int n_bad = 0;
  int cycle = 0;

  // reference model state
  logic [15:0] m_mem [16];
  bit          m_kn  [16];
  logic [48:0] sb_q  [6][$];   // {dont_care, due_cycle, data}
  logic [15:0] e_dout [6];
  bit          e_dc   [6];
  logic        e_coll = 1'b0;
  logic [15:0] e_cnt  = '0;

  always #5 clk = ~clk;

  dp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_w[0]), .valid_a(valid_w[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_w[1]), .valid_b(valid_w[1]),
    .coll(coll_w[0]), .coll_cnt(cnt_w[0]));

  dp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_w[2]), .valid_a(valid_w[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_w[3]), .valid_b(valid_w[3]),
    .coll(coll_w[1]), .coll_cnt(cnt_w[1]));

  dp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(2), .OUT_REG(0)) u2 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_w[4]), .valid_a(valid_w[4]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_w[5]), .valid_b(valid_w[5]),
    .coll(coll_w[2]), .coll_cnt(cnt_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic set_a(input logic e, input logic w, input logic [1:0] be,
                       input logic [3:0] ad, input logic [15:0] d);
    en_a = e; we_a = w; be_a = be; addr_a = ad; din_a = d;
  endtask

  task automatic set_b(input logic e, input logic w, input logic [1:0] be,
                       input logic [3:0] ad, input logic [15:0] d);
    en_b = e; we_b = w; be_b = be; addr_b = ad; din_b = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    set_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
  endtask

  task automatic push(input int k, input logic [15:0] d, input bit kn);
    sb_q[k].push_back({~kn, 32'(cycle + 1 + ORG[k / 2]), d});
  endtask

  // Apply current inputs to the model, clock once, then compare all outputs.
  task automatic step();
    logic        acc [2];
    logic        wr  [2];
    logic        wep [2];
    logic [15:0] old [2];
    logic [15:0] fin [2];
    bit          kn_o [2];
    bit          kn_f [2];
    logic        col;
    logic [1:0]  cov_a, cov_b;
    logic [48:0] ent;
    bit          ev;
    acc[0] = en_a & rst_n;
    acc[1] = en_b & rst_n;
    wep[0] = we_a;
    wep[1] = we_b;
    wr[0]  = acc[0] & we_a;
    wr[1]  = acc[1] & we_b;
    col    = acc[0] && acc[1] && (addr_a == addr_b) && (we_a || we_b);
    old[0] = m_mem[addr_a];  kn_o[0] = m_kn[addr_a];
    old[1] = m_mem[addr_b];  kn_o[1] = m_kn[addr_b];
    fin[0] = old[0];
    fin[1] = old[1];
    for (int i = 0; i < 2; i++) begin
      if (wr[1] && be_b[i]) begin
        fin[1][8*i +: 8] = din_b[8*i +: 8];
        if (col) fin[0][8*i +: 8] = din_b[8*i +: 8];
      end
      if (wr[0] && be_a[i]) begin
        fin[0][8*i +: 8] = din_a[8*i +: 8];
        if (col) fin[1][8*i +: 8] = din_a[8*i +: 8];
      end
    end
    cov_a = (wr[0] ? be_a : 2'b00) | ((col && wr[1]) ? be_b : 2'b00);
    cov_b = (wr[1] ? be_b : 2'b00) | ((col && wr[0]) ? be_a : 2'b00);
    kn_f[0] = kn_o[0] || (cov_a == 2'b11);
    kn_f[1] = kn_o[1] || (cov_b == 2'b11);
    for (int j = 0; j < NI; j++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          if (!wep[p] || MD[j] == 0) push(j*2 + p, old[p], kn_o[p]);
          else if (MD[j] == 1)       push(j*2 + p, fin[p], kn_f[p]);
        end
      end
    end
    if (wr[1]) begin m_mem[addr_b] = fin[1]; m_kn[addr_b] = kn_f[1]; end
    if (wr[0]) begin m_mem[addr_a] = fin[0]; m_kn[addr_a] = kn_f[0]; end
    if (!rst_n) begin
      e_coll = 1'b0;
      e_cnt  = '0;
      for (int k = 0; k < 6; k++) begin
        sb_q[k].delete();
        e_dout[k] = '0;
        e_dc[k]   = 1'b0;
      end
    end else begin
      e_coll = col;
      if (col && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    end

    @(posedge clk);
    cycle++;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      ev = 1'b0;
      if (sb_q[k].size() > 0) begin
        ent = sb_q[k][0];
        if (ent[47:16] == 32'(cycle)) begin
          ev = 1'b1;
          void'(sb_q[k].pop_front());
          e_dout[k] = ent[15:0];
          e_dc[k]   = ent[48];
        end
      end
      check($sformatf("valid%0d", k), 32'(valid_w[k]), 32'(ev));
      if (!e_dc[k]) check($sformatf("dout%0d", k), 32'(dout_w[k]), 32'(e_dout[k]));
    end
    for (int j = 0; j < NI; j++) begin
      check($sformatf("coll%0d", j), 32'(coll_w[j]), 32'(e_coll));
      check($sformatf("coll_cnt%0d", j), 32'(cnt_w[j]), 32'(e_cnt));
    end
  endtask

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    step();
    step();
    check("rst_cnt0", 32'(cnt_w[0]), 32'h0);
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      set_a(1'b1, 1'b1, 2'b11, 4'(a), 16'($urandom));
      step();
    end
    idle();
    step();

    // basic write then read on the other port
    set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hBEEF);
    step();
    idle();
    set_b(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
    step();
    check("basic_lat1", 32'(dout_w[1]), 32'hBEEF);
    idle();
    step();
    check("basic_lat2", 32'(dout_w[3]), 32'hBEEF);

    // byte enables
    set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h1234);
    step();
    set_a(1'b1, 1'b1, 2'b01, 4'd5, 16'hABCD);
    step();
    idle();
    set_b(1'b1, 1'b0, 2'b11, 4'd5, 16'h0000);
    step();
    check("byte_en", 32'(dout_w[1]), 32'h12CD);

    // read-during-write modes on port a
    idle();
    set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h0001);
    step();
    set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h0002);
    step();
    check("rf_dout", 32'(dout_w[0]), 32'h0001);
    check("rf_valid", 32'(valid_w[0]), 32'h1);
    check("nc_dout", 32'(dout_w[4]), 32'h0000);
    check("nc_valid", 32'(valid_w[4]), 32'h0);
    idle();
    step();
    check("wf_dout", 32'(dout_w[2]), 32'h0002);
    check("wf_valid", 32'(valid_w[2]), 32'h1);

    // double-write collision
    set_a(1'b1, 1'b1, 2'b10, 4'd2, 16'hAAAA);
    set_b(1'b1, 1'b1, 2'b11, 4'd2, 16'h5555);
    step();
    check("dwc_pulse", 32'(coll_w[0]), 32'h1);
    check("dwc_cnt", 32'(cnt_w[0]), 32'h1);
    idle();
    set_b(1'b1, 1'b0, 2'b11, 4'd2, 16'h0000);
    step();
    check("dwc_pulse_off", 32'(coll_w[0]), 32'h0);
    check("dwc_data", 32'(dout_w[1]), 32'hAA55);

    // read/write collision
    idle();
    set_a(1'b1, 1'b1, 2'b11, 4'd9, 16'h0F0F);
    step();
    set_a(1'b1, 1'b1, 2'b11, 4'd9, 16'hF0F0);
    set_b(1'b1, 1'b0, 2'b11, 4'd9, 16'h0000);
    step();
    check("rwc_old", 32'(dout_w[1]), 32'h0F0F);
    check("rwc_cnt", 32'(cnt_w[0]), 32'h2);
    idle();
    set_b(1'b1, 1'b0, 2'b11, 4'd9, 16'h0000);
    step();
    check("rwc_new", 32'(dout_w[1]), 32'hF0F0);

    // random traffic on a few addresses, occasional reset
    for (int n = 0; n < 400; n++) begin
      set_a($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
            4'($urandom_range(0, 3)), 16'($urandom));
      set_b($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
            4'($urandom_range(0, 3)), 16'($urandom));
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1;

    // reset while a read is in the OUT_REG pipeline
    idle();
    set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hBEEF);
    step();
    set_a(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
    step();
    rst_n = 1'b0;
    set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'h0000);
    set_b(1'b1, 1'b1, 2'b11, 4'd3, 16'h0000);
    step();
    check("rst_valid", 32'(valid_w[2]), 32'h0);
    check("rst_dout", 32'(dout_w[2]), 32'h0);
    check("rst_cnt", 32'(cnt_w[1]), 32'h0);
    rst_n = 1'b1;
    idle();
    step();
    check("rst_valid_after", 32'(valid_w[2]), 32'h0);
    set_a(1'b1, 1'b0, 2'b11, 4'd3, 16'h0000);
    step();
    idle();
    step();
    check("retain", 32'(dout_w[2]), 32'hBEEF);

    // drive the collision counter into saturation
    for (int n = 0; n < 65540; n++) begin
      set_a(1'b1, 1'b1, 2'b11, 4'd0, 16'(n));
      set_b(1'b1, 1'b0, 2'b11, 4'd0, 16'h0000);
      step();
    end
    check("sat_cnt0", 32'(cnt_w[0]), 32'hFFFF);
    check("sat_cnt1", 32'(cnt_w[1]), 32'hFFFF);
    check("sat_pulse", 32'(coll_w[0]), 32'h1);

    idle();
    step();
    step();
    step();
    for (int k = 0; k < 6; k++) check($sformatf("sb_left%0d", k), 32'(sb_q[k].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
